// File: rtl/wisc_pkg.sv
// Shared WISC decode constants: opcodes, immediate kinds, skid-buffer states and the extender.
// Purely declarative; no timing or handshake behaviour lives here.
package wisc_pkg;

  localparam int IW = 16;
  localparam int KW = 3;

  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;

  localparam logic [KW-1:0] KIND_NONE = 3'd0;
  localparam logic [KW-1:0] KIND_I5S  = 3'd1;
  localparam logic [KW-1:0] KIND_I5Z  = 3'd2;
  localparam logic [KW-1:0] KIND_I8S  = 3'd3;
  localparam logic [KW-1:0] KIND_I8Z  = 3'd4;
  localparam logic [KW-1:0] KIND_D11S = 3'd5;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [IW-1:0] imm;
    logic [KW-1:0] kind;
  } entry_t;

  function automatic logic [IW-1:0] ext_imm(input logic [KW-1:0] kind, input logic [IW-1:0] i);
    logic [IW-1:0] r;
    r = '0;
    case (kind)
      KIND_I5S:  r = {{11{i[4]}}, i[4:0]};
      KIND_I5Z:  r = {11'b0, i[4:0]};
      KIND_I8S:  r = {{8{i[7]}}, i[7:0]};
      KIND_I8Z:  r = {8'b0, i[7:0]};
      KIND_D11S: r = {{5{i[10]}}, i[10:0]};
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_sched_if.sv
// Fetch-to-decode instruction handshake plus decoded head-entry outputs.
// master drives instructions and out_ready; slave is the scheduler.
interface imm_sched_if;
  import wisc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [IW-1:0] out_imm;
  logic [KW-1:0] out_kind;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_kind
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_kind
  );

endinterface

// File: rtl/imm_kind_decode.sv
// Opcode to immediate-kind classifier; purely combinational, zero latency.
// No handshake: caller qualifies the result with its own valid.
module imm_kind_decode
  import wisc_pkg::*;
(
  input  logic [4:0]    opcode,
  output logic [KW-1:0] kind
);

  always_comb begin
    kind = KIND_NONE;
    case (opcode)
      OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU:
        kind = KIND_I5S;
      OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI:
        kind = KIND_I5Z;
      OP_LBI, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR, OP_JALR:
        kind = KIND_I8S;
      OP_SLBI:
        kind = KIND_I8Z;
      OP_J, OP_JAL:
        kind = KIND_D11S;
      default:
        kind = KIND_NONE;
    endcase
  end

endmodule

// File: rtl/imm_sched.sv
// Decode-stage immediate scheduler: classify, extend, then hold in a 2-entry skid buffer.
// One cycle accept-to-output; in_ready depends on buffer occupancy only, never on out_ready.
module imm_sched
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  imm_sched_if.slave  bus
);

  skid_state_e   state_q, state_d;
  entry_t        head_q, head_d;
  entry_t        tail_q, tail_d;

  logic [IW-1:0] instr_in;
  logic [KW-1:0] kind_in;
  entry_t        in_e;
  logic          in_xfer;
  logic          out_xfer;

  // Mask the bus while idle so an undriven word cannot leak X into the buffer.
  assign instr_in = bus.in_valid ? bus.in_instr : '0;

  imm_kind_decode u_dec (
    .opcode (instr_in[15:11]),
    .kind   (kind_in)
  );

  always_comb begin
    in_e       = '0;
    in_e.instr = instr_in;
    in_e.kind  = kind_in;
    in_e.imm   = ext_imm(kind_in, instr_in);
  end

  assign bus.in_ready  = (state_q != SK_TWO);
  assign bus.out_valid = (state_q != SK_EMPTY);
  assign bus.out_instr = head_q.instr;
  assign bus.out_imm   = head_q.imm;
  assign bus.out_kind  = head_q.kind;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SK_EMPTY: begin
        if (in_xfer) begin
          head_d  = in_e;
          state_d = SK_ONE;
        end
      end
      SK_ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = in_e;
        end else if (in_xfer) begin
          tail_d  = in_e;
          state_d = SK_TWO;
        end else if (out_xfer) begin
          head_d  = '0;
          state_d = SK_EMPTY;
        end
      end
      SK_TWO: begin
        // in_ready is low here, so only the drain path exists.
        if (out_xfer) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = SK_ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = SK_EMPTY;
      end
    endcase
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      state_d = SK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SK_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready && !flush) |=> $stable(head_q));

  a_full_blocks_input: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SK_TWO) |-> !bus.in_ready);

endmodule

// File: tb/tb_imm_sched.sv
// Scoreboard bench for imm_sched: directed decode/stall/flush/reset vectors plus a random valid/ready run.
module tb_imm_sched;
  import wisc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  imm_sched_if bus();

  imm_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [2:0]  kind;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic [15:0] exp_imm_drv  = '0;
  logic [2:0]  exp_kind_drv = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-response producer: every accepted word is queued with its hand/model expectation.
  always @(negedge clk) begin
    if (!rst_n || flush) sb.delete();
    else if (bus.in_valid && bus.in_ready)
      sb.push_back('{bus.in_instr, exp_imm_drv, exp_kind_drv});
  end

  // Monitor: pops on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got instr %h expected no output", bus.out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_instr", bus.out_instr, e.instr);
        chk("out_imm",   bus.out_imm,   e.imm);
        chk("out_kind",  bus.out_kind,  e.kind);
      end
    end
  end

  function automatic exp_t model(input logic [15:0] i);
    exp_t r;
    logic [4:0] op;
    op = i[15:11];
    r.instr = i;
    if (op inside {5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011}) r.kind = 3'd1;
    else if (op inside {5'b01010, 5'b01011} || op[4:2] == 3'b101) r.kind = 3'd2;
    else if (op == 5'b11000 || op[4:2] == 3'b011 || op == 5'b00101 || op == 5'b00111) r.kind = 3'd3;
    else if (op == 5'b10010) r.kind = 3'd4;
    else if (op == 5'b00100 || op == 5'b00110) r.kind = 3'd5;
    else r.kind = 3'd0;
    case (r.kind)
      3'd1:    r.imm = {{11{i[4]}}, i[4:0]};
      3'd2:    r.imm = {11'b0, i[4:0]};
      3'd3:    r.imm = {{8{i[7]}}, i[7:0]};
      3'd4:    r.imm = {8'b0, i[7:0]};
      3'd5:    r.imm = {{5{i[10]}}, i[10:0]};
      default: r.imm = 16'h0000;
    endcase
    return r;
  endfunction

  // Call just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [15:0] ins, input logic [15:0] eimm, input logic [2:0] ekind);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    exp_imm_drv  = eimm;
    exp_kind_drv = ekind;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready 0 for 20 cycles expected 1");
    bus.in_valid = 1'b0;
  endtask

  logic [15:0] dv_instr [6] = '{16'h41F0, 16'h5010, 16'h6080, 16'h9080, 16'h2400, 16'h0000};
  logic [15:0] dv_imm   [6] = '{16'hFFF0, 16'h0010, 16'hFF80, 16'h0080, 16'hFC00, 16'h0000};
  logic [2:0]  dv_kind  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    int   t0;
    logic acc;
    exp_t m;

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_instr", bus.out_instr, 16'h0);
    chk("rst_out_imm",   bus.out_imm,   16'h0);
    chk("rst_out_kind",  bus.out_kind,  3'd0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep with one-cycle latency check.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(dv_instr[k], dv_imm[k], dv_kind[k]);
      @(negedge clk);
      chk("lat_out_valid", bus.out_valid, 1'b1);
      chk("lat_out_kind",  bus.out_kind,  dv_kind[k]);
      @(posedge clk); #1;
    end

    // Stall: A held, B buffered, C refused until the head drains.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 16'h41F0; exp_imm_drv = 16'hFFF0; exp_kind_drv = 3'd1;
    @(negedge clk);
    chk("stall_rdy_a", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_instr = 16'h5010; exp_imm_drv = 16'h0010; exp_kind_drv = 3'd2;
    @(negedge clk);
    chk("stall_head_a", bus.out_instr, 16'h41F0);
    chk("stall_rdy_b", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_instr = 16'h6080; exp_imm_drv = 16'hFF80; exp_kind_drv = 3'd3;
    @(negedge clk);
    chk("stall_full", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold_rdy",  bus.in_ready, 1'b0);
    chk("stall_hold_head", bus.out_instr, 16'h41F0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h6080, 16'hFF80, 3'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_drained", sb.size(), 0);

    // Streaming through ONE: one word per cycle.
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      m = model(16'h4000 + 16'(k * 16'h0803));
      send(m.instr, m.imm, m.kind);
    end
    chk("stream_cycles", cyc - t0, 8);
    repeat (3) @(posedge clk);
    #1;

    // Flush in TWO with a word arriving.
    bus.out_ready = 1'b0;
    send(16'h41F0, 16'hFFF0, 3'd1);
    send(16'h5010, 16'h0010, 3'd2);
    bus.in_valid = 1'b1; bus.in_instr = 16'h2400; exp_imm_drv = 16'hFC00; exp_kind_drv = 3'd5;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready",  bus.in_ready,  1'b1);
    chk("flush_out_kind",  bus.out_kind,  3'd0);
    chk("flush_out_imm",   bus.out_imm,   16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_dropped", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Random valid/ready against the model.
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.in_valid || acc) begin
        m = model(16'($urandom));
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_instr = m.instr;
        exp_imm_drv  = m.imm;
        exp_kind_drv = m.kind;
      end
      flush = ($urandom_range(0, 59) == 0);
      bus.out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = bus.in_valid && (bus.in_ready || flush);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("random_drained", sb.size(), 0);

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    send(16'h9080, 16'h0080, 3'd4);
    send(16'h2400, 16'hFC00, 3'd5);
    @(negedge clk);
    chk("pre_reset_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_kind",  bus.out_kind,  3'd0);
    chk("arst_in_ready",  bus.in_ready,  1'b1);
    chk("arst_out_instr", bus.out_instr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h9080, 16'h0080, 3'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
